// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: status codes, icodes, register ids and run-state encoding.
package y86_pkg;

    // Status codes carried alongside each instruction
    localparam logic [3:0] SAOK = 4'd1;
    localparam logic [3:0] SHLT = 4'd2;
    localparam logic [3:0] SADR = 4'd3;
    localparam logic [3:0] SINS = 4'd4;

    // Instruction codes
    localparam logic [3:0] IHALT   = 4'd0;
    localparam logic [3:0] INOP    = 4'd1;
    localparam logic [3:0] IMRMOVQ = 4'd5;
    localparam logic [3:0] IOPQ    = 4'd6;
    localparam logic [3:0] IJXX    = 4'd7;
    localparam logic [3:0] IRET    = 4'd9;
    localparam logic [3:0] IPOPQ   = 4'd11;

    // Register id meaning "no register"
    localparam logic [3:0] RNONE = 4'hF;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StHalt = 2'd2
    } run_state_e;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the control unit (slave).
interface pipe_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    // Datapath observations
    logic             start;
    logic [3:0]       D_icode;
    logic [3:0]       d_srcA;
    logic [3:0]       d_srcB;
    logic [3:0]       E_icode;
    logic [3:0]       E_dstM;
    logic             e_Cnd;
    logic [3:0]       M_icode;
    logic [3:0]       m_stat;
    logic [3:0]       W_icode;
    logic [3:0]       W_stat;

    // Stage controls and status
    logic             F_stall;
    logic             D_stall;
    logic             D_bubble;
    logic             E_bubble;
    logic             M_bubble;
    logic             W_stall;
    logic             set_cc;
    logic             halted;
    logic [1:0]       run_state;
    logic [3:0]       final_stat;

    // Performance counters
    logic [CNT_W-1:0] cyc_cnt;
    logic [CNT_W-1:0] ret_cnt_i;
    logic [CNT_W-1:0] lu_cnt;
    logic [CNT_W-1:0] mp_cnt;
    logic [CNT_W-1:0] rb_cnt;

    modport master (
        output start, D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd,
               M_icode, m_stat, W_icode, W_stat,
        input  F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc,
               halted, run_state, final_stat,
               cyc_cnt, ret_cnt_i, lu_cnt, mp_cnt, rb_cnt
    );

    modport slave (
        input  start, D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd,
               M_icode, m_stat, W_icode, W_stat,
        output F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc,
               halted, run_state, final_stat,
               cyc_cnt, ret_cnt_i, lu_cnt, mp_cnt, rb_cnt
    );

endinterface

// File: rtl/pipe_ctrl_perf_cnt.sv
// Wrapping event counter with enable and synchronous clear (clear wins).
module perf_cnt #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count: clear, increment on enable (wraps naturally), else hold
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk_i) begin
        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Y86-64 pipeline control: hazard decode, IDLE/RUN/HALT run state and perf counters.
module pipe_ctrl
    import y86_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input logic        clk,
    input logic        rst,
    pipe_ctrl_if.slave bus
);

    run_state_e state_q, state_d;
    logic [3:0] final_stat_q, final_stat_d;

    logic lu, rt, mp, mexc, wexc, run_act, retire;

    // Hazard terms
    always_comb begin
        lu      = ((bus.E_icode == IMRMOVQ) || (bus.E_icode == IPOPQ)) &&
                  (bus.E_dstM != RNONE) &&
                  ((bus.E_dstM == bus.d_srcA) || (bus.E_dstM == bus.d_srcB));
        rt      = (bus.D_icode == IRET) || (bus.E_icode == IRET) || (bus.M_icode == IRET);
        mp      = (bus.E_icode == IJXX) && !bus.e_Cnd;
        mexc    = (bus.m_stat != SAOK);
        wexc    = (bus.W_stat != SAOK);
        retire  = (bus.W_icode != INOP) && ((bus.W_stat == SAOK) || (bus.W_stat == SHLT));
        // Reset forces IDLE-style controls even while state_q still says RUN
        run_act = (state_q == StRun) && !rst;
    end

    // Run-state and captured final status registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            final_stat_q <= 4'd0;
        end else begin
            state_q      <= state_d;
            final_stat_q <= final_stat_d;
        end
    end

    // Next-state: start leaves IDLE, any non-AOK at write-back halts, HALT is absorbing
    always_comb begin
        state_d      = state_q;
        final_stat_d = final_stat_q;
        case (state_q)
            StIdle: if (bus.start) state_d = StRun;
            StRun: begin
                if (wexc) begin
                    state_d      = StHalt;
                    final_stat_d = bus.W_stat;
                end
            end
            StHalt:  state_d = StHalt;
            default: state_d = StIdle;
        endcase
    end

    // Stage controls: frozen pipe outside RUN, hazard-driven inside
    always_comb begin
        bus.F_stall  = 1'b1;
        bus.D_stall  = 1'b1;
        bus.D_bubble = 1'b0;
        bus.E_bubble = 1'b0;
        bus.M_bubble = 1'b0;
        bus.W_stall  = 1'b1;
        bus.set_cc   = 1'b0;
        if (run_act) begin
            bus.F_stall  = lu | rt;
            bus.D_stall  = lu;
            // Load-use takes priority over the ret bubble in decode
            bus.D_bubble = mp | (!lu & rt);
            bus.E_bubble = mp | lu;
            bus.M_bubble = mexc | wexc;
            bus.W_stall  = wexc;
            bus.set_cc   = (bus.E_icode == IOPQ) & !mexc & !wexc;
        end
    end

    assign bus.run_state  = state_q;
    assign bus.halted     = (state_q == StHalt);
    assign bus.final_stat = final_stat_q;

    perf_cnt #(.CNT_W(CNT_W)) u_cyc_cnt (
        .clk_i (clk),
        .clr_i (rst),
        .en_i  (run_act),
        .cnt_o (bus.cyc_cnt)
    );

    perf_cnt #(.CNT_W(CNT_W)) u_ret_cnt (
        .clk_i (clk),
        .clr_i (rst),
        .en_i  (run_act & retire),
        .cnt_o (bus.ret_cnt_i)
    );

    perf_cnt #(.CNT_W(CNT_W)) u_lu_cnt (
        .clk_i (clk),
        .clr_i (rst),
        .en_i  (run_act & lu),
        .cnt_o (bus.lu_cnt)
    );

    perf_cnt #(.CNT_W(CNT_W)) u_mp_cnt (
        .clk_i (clk),
        .clr_i (rst),
        .en_i  (run_act & mp),
        .cnt_o (bus.mp_cnt)
    );

    perf_cnt #(.CNT_W(CNT_W)) u_rb_cnt (
        .clk_i (clk),
        .clr_i (rst),
        .en_i  (run_act & !lu & rt),
        .cnt_o (bus.rb_cnt)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed test-plan sequences followed by random traffic.
module tb_pipe_ctrl;

    localparam int unsigned CW = 4;

    typedef struct packed {
        logic       rst;
        logic       start;
        logic [3:0] D_icode;
        logic [3:0] d_srcA;
        logic [3:0] d_srcB;
        logic [3:0] E_icode;
        logic [3:0] E_dstM;
        logic       e_Cnd;
        logic [3:0] M_icode;
        logic [3:0] m_stat;
        logic [3:0] W_icode;
        logic [3:0] W_stat;
    } stim_t;

    typedef struct packed {
        logic [6:0]    ctl;
        logic [1:0]    st;
        logic [3:0]    fs;
        logic [CW-1:0] cyc;
        logic [CW-1:0] ret;
        logic [CW-1:0] lu;
        logic [CW-1:0] mp;
        logic [CW-1:0] rb;
    } exp_t;

    logic clk;
    logic rst;

    pipe_ctrl_if #(.CNT_W(CW)) bus ();

    pipe_ctrl #(.CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t expq[$];

    // Reference model state
    int         m_state = 0;
    logic [3:0] m_fs    = 4'd0;
    int         m_cnt[5] = '{0, 0, 0, 0, 0};

    logic [3:0] icodes[7] = '{4'd0, 4'd1, 4'd5, 4'd6, 4'd7, 4'd9, 4'd11};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic stim_t nop_stim();
        stim_t s;
        s.rst = 1'b0;     s.start = 1'b0;
        s.D_icode = 4'd1; s.d_srcA = 4'hF; s.d_srcB = 4'hF;
        s.E_icode = 4'd1; s.E_dstM = 4'hF; s.e_Cnd = 1'b1;
        s.M_icode = 4'd1; s.m_stat = 4'd1;
        s.W_icode = 4'd1; s.W_stat = 4'd1;
        return s;
    endfunction

    function automatic logic [3:0] pick_reg();
        logic [3:0] r;
        r = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 4));
        return r;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.rst     = ($urandom_range(0, 199) == 0);
        s.start   = ($urandom_range(0, 9) == 0);
        s.D_icode = icodes[$urandom_range(0, 6)];
        s.d_srcA  = pick_reg();
        s.d_srcB  = pick_reg();
        s.E_icode = icodes[$urandom_range(0, 6)];
        s.E_dstM  = pick_reg();
        s.e_Cnd   = 1'($urandom_range(0, 1));
        s.M_icode = icodes[$urandom_range(0, 6)];
        s.m_stat  = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(2, 4)) : 4'd1;
        s.W_icode = icodes[$urandom_range(0, 6)];
        s.W_stat  = ($urandom_range(0, 59) == 0) ? 4'($urandom_range(2, 4)) : 4'd1;
        return s;
    endfunction

    // Drive one cycle of stimulus, push the expected response, advance the model
    task automatic cycle(input stim_t s);
        exp_t e;
        bit lu, rt, mp, mx, wx, run, retire;
        @(posedge clk);
        #1;
        rst         = s.rst;
        bus.start   = s.start;
        bus.D_icode = s.D_icode;
        bus.d_srcA  = s.d_srcA;
        bus.d_srcB  = s.d_srcB;
        bus.E_icode = s.E_icode;
        bus.E_dstM  = s.E_dstM;
        bus.e_Cnd   = s.e_Cnd;
        bus.M_icode = s.M_icode;
        bus.m_stat  = s.m_stat;
        bus.W_icode = s.W_icode;
        bus.W_stat  = s.W_stat;

        lu     = (s.E_icode inside {4'd5, 4'd11}) && s.E_dstM != 4'hF &&
                 (s.E_dstM == s.d_srcA || s.E_dstM == s.d_srcB);
        rt     = (s.D_icode == 4'd9) || (s.E_icode == 4'd9) || (s.M_icode == 4'd9);
        mp     = (s.E_icode == 4'd7) && !s.e_Cnd;
        mx     = (s.m_stat != 4'd1);
        wx     = (s.W_stat != 4'd1);
        run    = (m_state == 1) && !s.rst;
        retire = (s.W_icode != 4'd1) && (s.W_stat == 4'd1 || s.W_stat == 4'd2);

        // ctl = {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc}
        if (run) e.ctl = {lu || rt, lu, mp || (!lu && rt), mp || lu, mx || wx, wx,
                          (s.E_icode == 4'd6) && !mx && !wx};
        else     e.ctl = 7'b1100010;
        e.st  = 2'(m_state);
        e.fs  = m_fs;
        e.cyc = CW'(m_cnt[0]);
        e.ret = CW'(m_cnt[1]);
        e.lu  = CW'(m_cnt[2]);
        e.mp  = CW'(m_cnt[3]);
        e.rb  = CW'(m_cnt[4]);
        expq.push_back(e);

        if (s.rst) begin
            m_state = 0;
            m_fs    = 4'd0;
            for (int i = 0; i < 5; i++) m_cnt[i] = 0;
        end else if (m_state == 0) begin
            if (s.start) m_state = 1;
        end else if (m_state == 1) begin
            m_cnt[0] = (m_cnt[0] + 1) % (1 << CW);
            if (retire)    m_cnt[1] = (m_cnt[1] + 1) % (1 << CW);
            if (lu)        m_cnt[2] = (m_cnt[2] + 1) % (1 << CW);
            if (mp)        m_cnt[3] = (m_cnt[3] + 1) % (1 << CW);
            if (!lu && rt) m_cnt[4] = (m_cnt[4] + 1) % (1 << CW);
            if (wx) begin
                m_state = 2;
                m_fs    = s.W_stat;
            end
        end
    endtask

    // Monitor: compare the presented outputs against the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            check("controls", 32'({bus.F_stall, bus.D_stall, bus.D_bubble, bus.E_bubble,
                                   bus.M_bubble, bus.W_stall, bus.set_cc}), 32'(e.ctl));
            check("run_state", 32'(bus.run_state), 32'(e.st));
            check("halted", 32'(bus.halted), 32'(e.st == 2'd2));
            check("final_stat", 32'(bus.final_stat), 32'(e.fs));
            check("cyc_cnt", 32'(bus.cyc_cnt), 32'(e.cyc));
            check("ret_cnt_i", 32'(bus.ret_cnt_i), 32'(e.ret));
            check("lu_cnt", 32'(bus.lu_cnt), 32'(e.lu));
            check("mp_cnt", 32'(bus.mp_cnt), 32'(e.mp));
            check("rb_cnt", 32'(bus.rb_cnt), 32'(e.rb));
        end
    end

    initial begin
        stim_t s;
        int    drain;
        s           = nop_stim();
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.D_icode = s.D_icode; bus.d_srcA = s.d_srcA; bus.d_srcB = s.d_srcB;
        bus.E_icode = s.E_icode; bus.E_dstM = s.E_dstM; bus.e_Cnd = s.e_Cnd;
        bus.M_icode = s.M_icode; bus.m_stat = s.m_stat;
        bus.W_icode = s.W_icode; bus.W_stat = s.W_stat;

        // Reset, idle, start, run
        s = nop_stim(); s.rst = 1'b1;
        repeat (2) cycle(s);
        s = nop_stim();
        repeat (2) cycle(s);
        s.start = 1'b1; cycle(s);
        s.start = 1'b0; repeat (3) cycle(s);

        // Load-use, then same with no destination
        s = nop_stim(); s.E_icode = 4'd5; s.E_dstM = 4'd3; s.d_srcA = 4'd3; cycle(s);
        s.E_dstM = 4'hF; cycle(s);
        s.E_icode = 4'd11; s.E_dstM = 4'd2; s.d_srcB = 4'd2; cycle(s);

        // Mispredict, then taken jump
        s = nop_stim(); s.E_icode = 4'd7; s.e_Cnd = 1'b0; cycle(s);
        s.e_Cnd = 1'b1; cycle(s);
        // Ret in D behind mispredicted jump
        s.e_Cnd = 1'b0; s.D_icode = 4'd9; cycle(s);

        // Ret walk D -> E -> M, then ret with load-use
        s = nop_stim(); s.D_icode = 4'd9; cycle(s);
        s = nop_stim(); s.E_icode = 4'd9; cycle(s);
        s = nop_stim(); s.M_icode = 4'd9; cycle(s);
        s.E_icode = 4'd5; s.E_dstM = 4'd1; s.d_srcA = 4'd1; cycle(s);

        // Exception in memory, then at write-back, then frozen with start pulses
        s = nop_stim(); s.E_icode = 4'd6; cycle(s);
        s.m_stat = 4'd3; cycle(s);
        s = nop_stim(); s.W_stat = 4'd3; cycle(s);
        s = nop_stim(); s.start = 1'b1; repeat (3) cycle(s);
        s.start = 1'b0; s.E_icode = 4'd5; s.E_dstM = 4'd0; s.d_srcA = 4'd0; cycle(s);
        s = nop_stim(); s.rst = 1'b1; cycle(s);
        s.rst = 1'b0; cycle(s);

        // Retire count: 4 OPs interleaved with 2 NOPs, then HALT status
        s = nop_stim(); s.start = 1'b1; cycle(s);
        s = nop_stim();
        s.W_icode = 4'd6; cycle(s);
        s.W_icode = 4'd1; cycle(s);
        s.W_icode = 4'd6; cycle(s);
        s.W_icode = 4'd6; cycle(s);
        s.W_icode = 4'd1; cycle(s);
        s.W_icode = 4'd6; cycle(s);
        s.W_icode = 4'd0; s.W_stat = 4'd2; cycle(s);
        s = nop_stim(); cycle(s);
        @(negedge clk);
        #1;
        check("retire_total", 32'(bus.ret_cnt_i), 32'd5);
        check("retire_halted", 32'(bus.halted), 32'd1);
        check("retire_final_stat", 32'(bus.final_stat), 32'd2);
        // Cycles counted: start-exit cycle excluded, 7 RUN cycles
        check("retire_cycles", 32'(bus.cyc_cnt), 32'd7);

        // Random traffic (begin from a clean reset)
        s = nop_stim(); s.rst = 1'b1; cycle(s);
        for (int i = 0; i < 3000; i++) begin
            cycle(rand_stim());
        end

        drain = 0;
        while (expq.size() > 0 && drain < 10) begin
            @(posedge clk);
            drain++;
        end
        if (expq.size() > 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", expq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
